// File: rtl/mem_access_ctrl.sv
// Initiator-side data-memory access controller for the pipeline MEM stage.
// Holds one load/store against a ready-handshake memory, trapping bad addresses and timeouts.
module mem_access_ctrl #(
    parameter int ADDR_LIMIT = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bad_addr;
    logic               last_cycle;
    logic               in_req;

    assign bad_addr   = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(ADDR_LIMIT));
    // cnt_q holds the number of REQ cycles already spent, so TIMEOUT-1 marks the final one.
    assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign in_req     = (state_q == REQ);

    // NOTE: next-state logic is combinational, so every output gets a default first to avoid latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = bad_addr ? RESP : REQ;
            REQ:     if (mem_ready_i || last_cycle) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        err_q   <= bad_addr;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_ready_i) begin
                        err_q <= 1'b0;
                        if (!we_q) rdata_q <= mem_rdata_i;
                    end else if (last_cycle) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so the pipeline hold drops at once even while req_i is high.
    assign stall_o     = rst_i && (((state_q == IDLE) && req_i) || in_req);
    assign rdata_o     = rdata_q;
    assign done_o      = (state_q == RESP);
    assign err_o       = (state_q == RESP) && err_q;
    assign mem_addr_o  = in_req ? addr_q : '0;
    assign mem_wdata_o = (in_req && we_q) ? wdata_q : '0;
    assign mem_write_o = in_req && we_q;
    assign mem_read_o  = in_req && !we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever done_o pulses.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;

    mem_access_ctrl #(.ADDR_LIMIT(32), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .done_o(done_o), .err_o(err_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: tallies memory commands and stall cycles, and scores every done_o pulse.
    always @(negedge clk_i) begin
        if (mem_write_o) wr_cnt++;
        if (mem_read_o) rd_cnt++;
        if (stall_o) stall_cnt++;
        if (mem_write_o || mem_read_o) begin
            last_addr = mem_addr_o;
            if (mem_write_o) last_wdata = mem_wdata_o;
        end
        if (mem_write_o && mem_read_o) check("cmd_exclusive", 32'd1, 32'd0);
        if (err_o && !done_o) check("err_without_done", 32'd1, 32'd0);
        if (done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_err"}, {31'd0, err_o}, {31'd0, e.err});
                check({e.name, "_rdata"}, rdata_o, e.rdata);
                check({e.name, "_done_cycle"}, cyc, e.done_cyc);
            end
        end
    end

    // Issues one request at cycle 0; ready_at is the REQ cycle (1-based) raising mem_ready_i, 0 = never.
    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ready_at, input logic [31:0] rd_val,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                          input int exp_wr, input int exp_rd, input int exp_stall);
        int   wr0, rd0, st0;
        exp_t e;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        st0 = stall_cnt;
        e.name = name;
        e.err = exp_err;
        e.rdata = exp_rdata;
        e.done_cyc = cyc + exp_lat;
        exp_q.push_back(e);
        req_i = 1'b1;
        we_i = we;
        addr_i = addr;
        wdata_i = wdata;
        mem_rdata_i = rd_val;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        for (int n = 1; n <= exp_lat; n++) begin
            mem_ready_i = (n == ready_at);
            @(posedge clk_i);
            #1;
        end
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        if (exp_q.size() != 0) begin
            check({name, "_done_seen"}, 32'd0, 32'd1);
            exp_q.delete();
        end
        check({name, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({name, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({name, "_stall_cycles"}, 32'(stall_cnt - st0), 32'(exp_stall));
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_stall"}, {31'd0, stall_o}, 32'd0);
        check({name, "_rdata"}, rdata_o, 32'd0);
        check({name, "_done"}, {31'd0, done_o}, 32'd0);
        check({name, "_err"}, {31'd0, err_o}, 32'd0);
        check({name, "_mem_addr"}, mem_addr_o, 32'd0);
        check({name, "_mem_wdata"}, mem_wdata_o, 32'd0);
        check({name, "_mem_cmd"}, {30'd0, mem_write_o, mem_read_o}, 32'd0);
    endtask

    initial begin
        req_i = 1'b1;
        we_i = 1'b1;
        addr_i = 32'h8;
        #2;
        check_all_zero("reset");
        req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // name, we, addr, wdata, ready_at, rd_val, err, rdata, lat, writes, reads, stalls
        access("store_8", 1'b1, 32'h8, 32'hDEADBEEF, 1, 32'h0, 1'b0, 32'h0, 2, 1, 0, 2);
        check("store_8_mem_addr", last_addr, 32'h8);
        check("store_8_mem_wdata", last_wdata, 32'hDEADBEEF);
        access("load_8", 1'b0, 32'h8, 32'h0, 1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2, 0, 1, 2);
        check("load_8_mem_addr", last_addr, 32'h8);
        access("misaligned_6", 1'b0, 32'h6, 32'h0, 1, 32'h55555555, 1'b1, 32'hDEADBEEF, 1, 0, 0, 1);
        access("range_20", 1'b0, 32'h20, 32'h0, 1, 32'h55555555, 1'b1, 32'hDEADBEEF, 1, 0, 0, 1);
        access("load_4_wait3", 1'b0, 32'h4, 32'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 4, 0, 3, 4);
        check("load_4_mem_addr", last_addr, 32'h4);
        access("store_1c_top", 1'b1, 32'h1C, 32'h0BADF00D, 1, 32'h0, 1'b0, 32'h12345678, 2, 1, 0, 2);
        check("store_1c_mem_wdata", last_wdata, 32'h0BADF00D);
        access("store_timeout", 1'b1, 32'h10, 32'hA5A5A5A5, 0, 32'h0, 1'b1, 32'h12345678, 16, 15, 0, 16);
        access("load_ready15", 1'b0, 32'h10, 32'h0, 15, 32'h87654321, 1'b0, 32'h87654321, 16, 0, 15, 16);

        // Reset pulse while a load is stalled in REQ.
        req_i = 1'b1;
        we_i = 1'b0;
        addr_i = 32'h4;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("midreset_pre_read", {31'd0, mem_read_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        access("load_after_reset", 1'b0, 32'h8, 32'h0, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 2, 0, 1, 2);

        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global time limit reached");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that drives the single-port Data_Memory responder on behalf of the pipeline MEM stage. It accepts one load/store request at a time and holds it against the memory until a ready handshake arrives. It stalls the pipeline while the access is in flight, then returns read data with a done/error pulse. Bad addresses and unresponsive memory are trapped here rather than passed to the memory.

Parameters:
ADDR_LIMIT, 32, byte address bound; addresses >= ADDR_LIMIT are rejected (default = 8 words).
TIMEOUT, 15, maximum cycles spent in REQ waiting for mem_ready_i; must be >= 1.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
req_i  input  1  pipeline request valid; sampled only in IDLE.
we_i  input  1  1 = store, 0 = load.
addr_i  input  32  byte address.
wdata_i  input  32  store data.
stall_o  output  1  pipeline hold.
rdata_o  output  32  load result.
done_o  output  1  one-cycle completion pulse.
err_o  output  1  one-cycle error pulse, coincident with done_o.
mem_addr_o  output  32  address to memory.
mem_wdata_o  output  32  write data to memory.
mem_write_o  output  1  memory write command.
mem_read_o  output  1  memory read command.
mem_rdata_i  input  32  memory read data.
mem_ready_i  input  1  memory completion handshake.

Behaviour:
- Reset (rst_i=0, asynchronous): FSM goes to IDLE. Every output is 0, including rdata_o. The timeout counter and captured request registers clear. Memory commands drop immediately, even mid-access.
- FSM has three states: IDLE, REQ, RESP.
- IDLE, req_i=1: capture we_i, addr_i, wdata_i.
  - If addr_i[1:0]!=0 or addr_i>=ADDR_LIMIT, go to RESP with the error flag set. No memory command is issued.
  - Otherwise clear the counter and go to REQ.
- REQ, command: assert mem_read_o or mem_write_o (never both). Drive mem_addr_o with the captured address. Drive mem_wdata_o with the captured data for stores.
- REQ, ready: mem_ready_i=1 completes the access in that cycle. For a load, mem_rdata_i is registered into rdata_o. Go to RESP without error.
- REQ, timeout: the counter increments each REQ cycle. If mem_ready_i is still 0 in the TIMEOUT-th REQ cycle, go to RESP with error and rdata_o unchanged. Ready arriving in that final cycle counts as success.
- RESP: done_o=1 for exactly one cycle, err_o=error flag, then return to IDLE. req_i is ignored in RESP; the next request is accepted in IDLE.
- stall_o is combinational: 1 when (IDLE and req_i) or REQ; 0 in RESP and in idle IDLE.
- Outside REQ, mem_addr_o, mem_wdata_o, mem_read_o and mem_write_o are 0. mem_ready_i is ignored outside REQ.
- rdata_o holds its value until the next successful load; stores and errors leave it untouched.
- Latency: request at cycle 0, REQ from cycle 1, ready at cycle k (k>=1), done at cycle k+1. Zero-wait memory gives done at cycle 2. An error on capture gives done at cycle 1.
- Counter width is clog2(TIMEOUT+1) and it never wraps, because REQ exits at TIMEOUT.

Test Plan:
- Store then load, immediate ready: store 0xDEADBEEF to 0x8, then load 0x8 -> mem_write_o high for 1 cycle with addr 0x8; load gives rdata_o=0xDEADBEEF; done_o at cycle 2 each time; err_o=0.
- Load from 0x6 (misaligned) -> no mem command; done_o=err_o=1 at cycle 1; rdata_o unchanged.
- Load from 0x20 with ADDR_LIMIT=32 (out of range) -> done_o=err_o=1 at cycle 1; no mem command.
- Load from 0x4, mem_ready_i delayed 3 cycles, mem_rdata_i=0x12345678 -> mem_read_o high for 3 cycles and stall_o high for 4 cycles; done_o at cycle 4; rdata_o=0x12345678.
- Timeout: store with mem_ready_i stuck 0, TIMEOUT=15 -> mem_write_o high for exactly 15 cycles; done_o=err_o=1 at cycle 16. Repeat with ready in REQ cycle 15 -> success, err_o=0.
- Reset pulse asserted during REQ of a load -> all outputs 0 asynchronously; after release, FSM is in IDLE and a new load completes normally.
